// File: rtl/spi_slave_sync.sv
`default_nettype none
// ============================================================================
// Module      : spi_slave_sync
// Description : SPI slave, single clock domain. sck/cs/mosi are oversampled
//               through 2-flop synchronizers; one-deep transmit queue.
// Revision    : 1.0 - initial release
// ============================================================================
module spi_slave_sync #(
    parameter bit         CPOL       = 1'b0,
    parameter bit         CPHA       = 1'b0,
    parameter logic [7:0] DEFAULT_TX = 8'hA5
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       sck,
    input  logic       cs,
    input  logic       mosi,
    output logic       miso,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic       busy,
    output logic       abort
);

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    state_t      state_q, state_d;
    logic        sck_s1_q, sck_s1_d, sck_s2_q, sck_s2_d, sck_prev_q, sck_prev_d;
    logic        cs_s1_q, cs_s1_d, cs_s2_q, cs_s2_d;
    logic        mosi_s1_q, mosi_s1_d, mosi_s2_q, mosi_s2_d;
    logic [1:0]  fill_q, fill_d;
    logic        armed_q, armed_d;
    logic [2:0]  bit_cnt_q, bit_cnt_d;
    logic [6:0]  shift_in_q, shift_in_d;
    logic [7:0]  shift_out_q, shift_out_d;
    logic        q_valid_q, q_valid_d;
    logic [7:0]  q_data_q, q_data_d;
    logic [7:0]  rx_data_q, rx_data_d;
    logic        rx_valid_q, rx_valid_d;
    logic        abort_q, abort_d;

    logic        w_sck_edge, w_lead, w_trail, w_sample, w_drive;
    logic        w_accept, w_load_tx;

    always_comb begin
        state_d     = state_q;
        sck_s1_d    = sck;
        sck_s2_d    = sck_s1_q;
        sck_prev_d  = sck_s2_q;
        cs_s1_d     = cs;
        cs_s2_d     = cs_s1_q;
        mosi_s1_d   = mosi;
        mosi_s2_d   = mosi_s1_q;
        fill_d      = {fill_q[0], 1'b1};
        armed_d     = armed_q;
        bit_cnt_d   = bit_cnt_q;
        shift_in_d  = shift_in_q;
        shift_out_d = shift_out_q;
        q_valid_d   = q_valid_q;
        q_data_d    = q_data_q;
        rx_data_d   = rx_data_q;
        rx_valid_d  = 1'b0;
        abort_d     = 1'b0;
        w_load_tx   = 1'b0;

        w_sck_edge = (sck_s2_q != sck_prev_q);
        w_lead     = w_sck_edge && (sck_prev_q == CPOL);
        w_trail    = w_sck_edge && (sck_prev_q != CPOL);
        w_sample   = CPHA ? w_trail : w_lead;
        w_drive    = CPHA ? w_lead  : w_trail;
        w_accept   = tx_valid && !q_valid_q;

        // The reset value of the cs synchronizer is fake; only a cs high that
        // has really propagated through the chain arms the slave.
        if (fill_q[1] && cs_s2_q) begin
            armed_d = 1'b1;
        end

        if (w_accept) begin
            q_valid_d = 1'b1;
            q_data_d  = tx_data;
        end

        case (state_q)
            IDLE: begin
                if (armed_q && !cs_s2_q) begin
                    state_d   = SHIFT;
                    bit_cnt_d = 3'd0;
                    w_load_tx = 1'b1;
                end
            end
            SHIFT: begin
                if (cs_s2_q) begin
                    state_d   = IDLE;
                    bit_cnt_d = 3'd0;
                    abort_d   = (bit_cnt_q != 3'd0);
                end else if (w_sample) begin
                    shift_in_d = {shift_in_q[5:0], mosi_s2_q};
                    bit_cnt_d  = bit_cnt_q + 3'd1;
                    if (bit_cnt_q == 3'd7) begin
                        rx_data_d  = {shift_in_q, mosi_s2_q};
                        rx_valid_d = 1'b1;
                        w_load_tx  = 1'b1;
                    end
                end else if (w_drive && (bit_cnt_q != 3'd0)) begin
                    // The drive edge at count 0 would skip bit 7 of a freshly loaded byte.
                    shift_out_d = {shift_out_q[6:0], 1'b0};
                end
            end
            default: state_d = IDLE;
        endcase

        if (w_load_tx) begin
            shift_out_d = q_valid_q ? q_data_q : (w_accept ? tx_data : DEFAULT_TX);
            q_valid_d   = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            sck_s1_q    <= CPOL;
            sck_s2_q    <= CPOL;
            sck_prev_q  <= CPOL;
            cs_s1_q     <= 1'b1;
            cs_s2_q     <= 1'b1;
            mosi_s1_q   <= 1'b0;
            mosi_s2_q   <= 1'b0;
            fill_q      <= 2'b00;
            armed_q     <= 1'b0;
            bit_cnt_q   <= 3'd0;
            shift_in_q  <= 7'd0;
            shift_out_q <= 8'd0;
            q_valid_q   <= 1'b0;
            q_data_q    <= 8'd0;
            rx_data_q   <= 8'd0;
            rx_valid_q  <= 1'b0;
            abort_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            sck_s1_q    <= sck_s1_d;
            sck_s2_q    <= sck_s2_d;
            sck_prev_q  <= sck_prev_d;
            cs_s1_q     <= cs_s1_d;
            cs_s2_q     <= cs_s2_d;
            mosi_s1_q   <= mosi_s1_d;
            mosi_s2_q   <= mosi_s2_d;
            fill_q      <= fill_d;
            armed_q     <= armed_d;
            bit_cnt_q   <= bit_cnt_d;
            shift_in_q  <= shift_in_d;
            shift_out_q <= shift_out_d;
            q_valid_q   <= q_valid_d;
            q_data_q    <= q_data_d;
            rx_data_q   <= rx_data_d;
            rx_valid_q  <= rx_valid_d;
            abort_q     <= abort_d;
        end
    end

    assign busy     = (state_q == SHIFT);
    assign miso     = busy && shift_out_q[7];
    assign tx_ready = !q_valid_q;
    assign rx_data  = rx_data_q;
    assign rx_valid = rx_valid_q;
    assign abort    = abort_q;

endmodule
`default_nettype wire

// File: tb/tb_spi_slave_sync.sv
`default_nettype none
// ============================================================================
// Module      : tb_spi_slave_sync
// Description : Directed bench; one slave per SPI mode (index = {CPOL,CPHA}).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_spi_slave_sync;

    localparam int HP = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] sck = 4'b1100;
    logic [3:0] cs = 4'b1111;
    logic [3:0] mosi = 4'b0000;
    logic [3:0] miso, tx_ready, rx_valid, busy, abort;
    logic [3:0] tx_valid = 4'b0000;
    logic [7:0] tx_data [4];
    logic [7:0] rx_data [4];

    int n_checks = 0;
    int n_errors = 0;
    int rxv_cnt [4];
    int abort_cnt [4];

    always #5 clk = ~clk;

    for (genvar g = 0; g < 4; g++) begin : g_dut
        spi_slave_sync #(
            .CPOL       (1'((g >> 1) & 1)),
            .CPHA       (1'(g & 1)),
            .DEFAULT_TX (8'hA5)
        ) u_dut (
            .clk      (clk),
            .rst      (rst),
            .sck      (sck[g]),
            .cs       (cs[g]),
            .mosi     (mosi[g]),
            .miso     (miso[g]),
            .tx_data  (tx_data[g]),
            .tx_valid (tx_valid[g]),
            .tx_ready (tx_ready[g]),
            .rx_data  (rx_data[g]),
            .rx_valid (rx_valid[g]),
            .busy     (busy[g]),
            .abort    (abort[g])
        );
    end

    initial begin
        for (int k = 0; k < 4; k++) begin
            rxv_cnt[k]   = 0;
            abort_cnt[k] = 0;
            tx_data[k]   = 8'h00;
        end
    end

    always @(posedge clk) begin
        for (int k = 0; k < 4; k++) begin
            if (rx_valid[k]) rxv_cnt[k] <= rxv_cnt[k] + 1;
            if (abort[k])    abort_cnt[k] <= abort_cnt[k] + 1;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic wclk(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Master side: shifts nbits of tx MSB first, returns what was seen on miso.
    task automatic xfer_bits(input int m, input logic [7:0] tx, input int nbits,
                             output logic [7:0] rx);
        logic cpol, cpha;
        cpol = m[1];
        cpha = m[0];
        rx   = 8'h00;
        for (int i = 7; i > 7 - nbits; i--) begin
            if (!cpha) begin
                mosi[m] = tx[i];
                wclk(HP);
                sck[m] = ~cpol;
                rx[i]  = miso[m];
                wclk(HP);
                sck[m] = cpol;
            end else begin
                wclk(HP);
                sck[m]  = ~cpol;
                mosi[m] = tx[i];
                wclk(HP);
                sck[m] = cpol;
                rx[i]  = miso[m];
            end
        end
    endtask

    task automatic cs_release(input int m);
        wclk(HP);
        cs[m] = 1'b1;
        wclk(3 * HP);
    endtask

    task automatic frame(input int m, input logic [7:0] tx, output logic [7:0] rx);
        cs[m] = 1'b0;
        xfer_bits(m, tx, 8, rx);
        cs_release(m);
    endtask

    task automatic queue(input int m, input logic [7:0] d);
        tx_data[m]  = d;
        tx_valid[m] = 1'b1;
        wclk(1);
        tx_valid[m] = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] got, got2;
        int rv0, ab0;

        wclk(3);
        rst = 1'b0;
        check("rst_miso",     {31'd0, miso[0]},     32'd0);
        check("rst_tx_ready", {31'd0, tx_ready[0]}, 32'd1);
        check("rst_rx_data",  {24'd0, rx_data[0]},  32'h00);
        check("rst_rx_valid", {31'd0, rx_valid[0]}, 32'd0);
        check("rst_busy",     {31'd0, busy[0]},     32'd0);
        check("rst_abort",    {31'd0, abort[0]},    32'd0);
        wclk(8);

        // Mode 0, nothing queued: default byte returned
        rv0 = rxv_cnt[0];
        cs[0] = 1'b0;
        wclk(3);
        check("t1_busy",     {31'd0, busy[0]}, 32'd1);
        check("t1_miso_bit7", {31'd0, miso[0]}, 32'd1);
        xfer_bits(0, 8'h3C, 8, got);
        cs_release(0);
        check("t1_rx_data",  {24'd0, rx_data[0]}, 32'h3C);
        check("t1_rxv_count", rxv_cnt[0] - rv0, 32'd1);
        check("t1_master_rx", {24'd0, got}, 32'hA5);

        // Queued host byte
        queue(0, 8'h5A);
        check("t2_tx_ready_full", {31'd0, tx_ready[0]}, 32'd0);
        cs[0] = 1'b0;
        wclk(3);
        check("t2_tx_ready_entry", {31'd0, tx_ready[0]}, 32'd1);
        xfer_bits(0, 8'hFF, 8, got);
        cs_release(0);
        check("t2_rx_data",   {24'd0, rx_data[0]}, 32'hFF);
        check("t2_master_rx", {24'd0, got}, 32'h5A);

        // All four modes
        for (int m = 0; m < 4; m++) begin
            queue(m, 8'h7E);
            frame(m, 8'h81, got);
            check($sformatf("t3_rx_data_m%0d", m),   {24'd0, rx_data[m]}, 32'h81);
            check($sformatf("t3_master_rx_m%0d", m), {24'd0, got}, 32'h7E);
        end

        // Partial frame: 3 bits then cs high
        rv0 = rxv_cnt[0];
        ab0 = abort_cnt[0];
        cs[0] = 1'b0;
        xfer_bits(0, 8'hC3, 3, got);
        cs_release(0);
        check("t4_abort_count", abort_cnt[0] - ab0, 32'd1);
        check("t4_rxv_count",   rxv_cnt[0] - rv0, 32'd0);
        check("t4_rx_data_kept", {24'd0, rx_data[0]}, 32'h81);
        rv0 = rxv_cnt[0];
        frame(0, 8'h18, got);
        check("t4_rx_data_next", {24'd0, rx_data[0]}, 32'h18);
        check("t4_rxv_next",     rxv_cnt[0] - rv0, 32'd1);
        check("t4_master_rx",    {24'd0, got}, 32'hA5);

        // Back-to-back bytes under one cs low
        rv0 = rxv_cnt[0];
        queue(0, 8'h77);
        cs[0] = 1'b0;
        xfer_bits(0, 8'h11, 8, got);
        check("t5_rx_first", {24'd0, rx_data[0]}, 32'h11);
        check("t5_master_first", {24'd0, got}, 32'h77);
        xfer_bits(0, 8'h22, 8, got2);
        cs_release(0);
        check("t5_rx_second", {24'd0, rx_data[0]}, 32'h22);
        check("t5_master_second", {24'd0, got2}, 32'hA5);
        check("t5_rxv_count", rxv_cnt[0] - rv0, 32'd2);

        // Reset in the middle of a frame
        cs[0] = 1'b0;
        xfer_bits(0, 8'h96, 4, got);
        rst = 1'b1;
        wclk(1);
        rst = 1'b0;
        check("t6_miso",     {31'd0, miso[0]},     32'd0);
        check("t6_tx_ready", {31'd0, tx_ready[0]}, 32'd1);
        check("t6_rx_data",  {24'd0, rx_data[0]},  32'h00);
        check("t6_rx_valid", {31'd0, rx_valid[0]}, 32'd0);
        check("t6_busy",     {31'd0, busy[0]},     32'd0);
        check("t6_abort",    {31'd0, abort[0]},    32'd0);
        rv0 = rxv_cnt[0];
        ab0 = abort_cnt[0];
        // cs still low from before the reset: these clocks must be ignored
        xfer_bits(0, 8'hE7, 8, got);
        cs_release(0);
        check("t6_no_rxv",   rxv_cnt[0] - rv0, 32'd0);
        check("t6_no_abort", abort_cnt[0] - ab0, 32'd0);
        check("t6_still_idle_rx", {24'd0, rx_data[0]}, 32'h00);
        frame(0, 8'h3C, got);
        check("t6_rx_data_after", {24'd0, rx_data[0]}, 32'h3C);
        check("t6_rxv_after",     rxv_cnt[0] - rv0, 32'd1);
        check("t6_master_after",  {24'd0, got}, 32'hA5);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/spi_slave_sync.md
SPI_SLAVE_SYNC -- requirements
Module: spi_slave_sync

Interface
REQ-001 Parameter CPOL, default 0, SCK idle level.
REQ-002 Parameter CPHA, default 0: 0 = sample on leading edge, 1 = sample on trailing edge.
REQ-003 Parameter DEFAULT_TX, default 8'hA5, byte returned when no host byte is queued.
REQ-004 Port clk  input  1  system clock; all state on rising edge.
REQ-005 Port rst  input  1  synchronous, active-high reset.
REQ-006 Port sck  input  1  SPI clock from master, asynchronous to clk.
REQ-007 Port cs  input  1  chip select, active low, asynchronous.
REQ-008 Port mosi  input  1  serial data from master, asynchronous.
REQ-009 Port miso  output  1  serial data to master.
REQ-010 Port tx_data  input  8  next response byte from host.
REQ-011 Port tx_valid  input  1  tx_data offered.
REQ-012 Port tx_ready  output  1  queue empty; byte accepted when tx_valid && tx_ready.
REQ-013 Port rx_data  output  8  last complete received byte.
REQ-014 Port rx_valid  output  1  one-cycle pulse, rx_data updated.
REQ-015 Port busy  output  1  frame in progress (synchronized cs low).
REQ-016 Port abort  output  1  one-cycle pulse, frame ended with 1-7 bits.

Function
REQ-017 sck, cs and mosi SHALL each pass a 2-flop synchronizer; edges are detected on the synchronized signals; the design SHALL use no clock other than clk.
REQ-018 Supported SCK half-period: at least 4 clk cycles (master CLK_DIV >= 8).
REQ-019 States: IDLE, SHIFT. IDLE->SHIFT on synchronized cs falling; SHIFT->IDLE on synchronized cs rising, or after the 8th sample with cs still low, restarting SHIFT for the next byte (back-to-back frames).
REQ-020 On SHIFT entry, the shift-out register loads the queued byte and clears the queue; if empty, it loads DEFAULT_TX.
REQ-021 Bit order: MSB first, 8 bits per frame; bit counter 0..7 wraps to 0 after 8th sample.
REQ-022 Sample edge = leading when CPHA=0, trailing when CPHA=1; leading = sck leaving CPOL level.
REQ-023 CPHA=0: bit 7 is driven on miso within 3 clk of cs falling at the pin; each following bit on the trailing edge.
REQ-024 CPHA=1: each bit, including bit 7, is driven on the leading edge.
REQ-025 On the 8th sample, rx_data <= {shift_in[6:0], mosi_sync} and rx_valid pulses for exactly 1 cycle.
REQ-026 miso = 0 while not busy.
REQ-027 Queue depth 1: tx_ready = 1 when empty; a byte accepted during SHIFT applies to the next frame, never the current one.
REQ-028 tx_valid && tx_ready on the same cycle as SHIFT entry: the new byte is used for this frame.
REQ-029 cs rising with bit counter 1..7: abort pulses 1 cycle, no rx_valid, rx_data unchanged, partial bits discarded, queue unaffected.
REQ-030 cs rising with bit counter 0 (no bits): no abort, no rx_valid.
REQ-031 sck edges while cs high SHALL be ignored.

Reset
REQ-032 With rst high on a clk edge: state IDLE, counters 0, synchronizers loaded with idle levels (sck=CPOL, cs=1, mosi=0), queue empty.
REQ-033 Output reset values: miso=0, tx_ready=1, rx_data=8'h00, rx_valid=0, busy=0, abort=0.
REQ-034 Reset mid-frame SHALL abandon the frame without an abort or rx_valid pulse; after reset release the slave waits for a fresh cs falling edge.

Verification
REQ-035 Mode 0, master CLK_DIV=8, master sends 8'h3C, no host byte queued -> rx_data=8'h3C, rx_valid pulses once, master receives 8'hA5.
REQ-036 Host queues 8'h5A, then master sends 8'hFF -> rx_data=8'hFF, master receives 8'h5A, tx_ready returns to 1 at SHIFT entry.
REQ-037 All four CPOL/CPHA combinations, master sends 8'h81, slave queued 8'h7E -> both sides see the correct byte in every mode.
REQ-038 cs raised after 3 bits of 8'hC3 -> abort pulses once, rx_valid stays 0, rx_data keeps its prior value; the next full frame of 8'h18 is received correctly.
REQ-039 Two back-to-back frames under one cs low (8'h11, 8'h22) -> two rx_valid pulses with 8'h11 then 8'h22; the second response is DEFAULT_TX if the queue is empty.
REQ-040 rst asserted for 1 cycle after bit 4 -> all outputs return to reset values, no pulse; the following frame of 8'h3C is received correctly.
